// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_pkg
//  Description : Shared definitions for the multiply/divide unit. Holds the
//                op-code constants, the FSM state encoding and small decode
//                helpers used by muldiv_unit.
//  Revision    : 1.0  initial release
// ============================================================================
package mdu_pkg;

    // Op-code map. Codes 12-15 are no-ops.
    localparam logic [3:0] c_OP_MFHI  = 4'd0;
    localparam logic [3:0] c_OP_MFLO  = 4'd1;
    localparam logic [3:0] c_OP_MTHI  = 4'd2;
    localparam logic [3:0] c_OP_MTLO  = 4'd3;
    localparam logic [3:0] c_OP_MULT  = 4'd4;
    localparam logic [3:0] c_OP_MULTU = 4'd5;
    localparam logic [3:0] c_OP_DIV   = 4'd6;
    localparam logic [3:0] c_OP_DIVU  = 4'd7;
    localparam logic [3:0] c_OP_MADD  = 4'd8;
    localparam logic [3:0] c_OP_MADDU = 4'd9;
    localparam logic [3:0] c_OP_MSUB  = 4'd10;
    localparam logic [3:0] c_OP_MSUBU = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    // Multiply class: plain products and the HI/LO accumulate variants.
    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == c_OP_MULT) || (op == c_OP_MULTU) ||
               (op == c_OP_MADD) || (op == c_OP_MADDU) ||
               (op == c_OP_MSUB) || (op == c_OP_MSUBU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == c_OP_DIV) || (op == c_OP_DIVU);
    endfunction

    // Among the arithmetic ops every unsigned variant has an odd code.
    function automatic logic is_signed_op(input logic [3:0] op);
        return ~op[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_div_core.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_div_core
//  Description : Combinational WIDTH-bit divider producing quotient and
//                remainder, signed or unsigned. Signed quotient truncates
//                toward zero, remainder takes the dividend's sign.
//                Divide by zero yields quotient all-ones, remainder = dividend.
//                Most-negative / -1 yields quotient = dividend, remainder 0.
//  Ports       : i_a      dividend
//                i_b      divisor
//                i_signed 1 = two's-complement operands
//                o_quo    quotient
//                o_rem    remainder
//  Revision    : 1.0  initial release
// ============================================================================
module mdu_div_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_signed,
    output logic [WIDTH-1:0] o_quo,
    output logic [WIDTH-1:0] o_rem
);

    localparam logic [WIDTH-1:0] c_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_q_mag;
    logic [WIDTH-1:0] w_r_mag;

    // Divide magnitudes unsigned, then restore signs.
    assign w_a_neg = i_signed & i_a[WIDTH-1];
    assign w_b_neg = i_signed & i_b[WIDTH-1];
    assign w_a_mag = w_a_neg ? (~i_a + 1'b1) : i_a;
    assign w_b_mag = w_b_neg ? (~i_b + 1'b1) : i_b;
    assign w_q_mag = w_a_mag / w_b_mag;
    assign w_r_mag = w_a_mag % w_b_mag;

    always_comb begin
        o_quo = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 1'b1) : w_q_mag;
        o_rem = w_a_neg ? (~w_r_mag + 1'b1) : w_r_mag;
        if (i_b == '0) begin
            o_quo = '1;
            o_rem = i_a;
        end else if (i_signed && (i_a == c_MOST_NEG) && (i_b == '1)) begin
            o_quo = i_a;
            o_rem = '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : MIPS-style HI/LO multiply/divide unit. Multiply-class ops
//                take MUL_LAT cycles, divide-class ops DIV_LAT cycles; MTHI/
//                MTLO complete in one cycle. Starts are ignored while busy.
//  Ports       : clk     clock, rising edge
//                reset   synchronous active-high reset
//                start   issue op this cycle
//                op      operation code (see mdu_pkg)
//                a, b    source operands (rs, rt)
//                busy    multi-cycle op in progress
//                done    one-cycle pulse after HI/LO written by a long op
//                result  HI for MFHI, LO for MFLO, else zero (combinational)
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int c_MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int c_CNT_W   = $clog2(c_MAX_LAT + 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [3:0]           r_op;
    logic                 r_done;

    logic                 w_last;
    logic                 w_sx;
    logic [2*WIDTH-1:0]   w_a_ext;
    logic [2*WIDTH-1:0]   w_b_ext;
    logic [2*WIDTH-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_hilo;
    logic [2*WIDTH-1:0]   w_mul_res;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    assign w_last = (r_cnt == c_CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (is_mul_op(op)) begin
                        w_state_nxt = ST_MUL;
                    end else if (is_div_op(op)) begin
                        w_state_nxt = ST_DIV;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Arithmetic on the latched operands
    // ------------------------------------------------------------------
    // Extending to 2*WIDTH and keeping the low 2*WIDTH product bits gives
    // the correct full product for both signed and unsigned operands.
    assign w_sx    = is_signed_op(r_op);
    assign w_a_ext = {{WIDTH{w_sx & r_a[WIDTH-1]}}, r_a};
    assign w_b_ext = {{WIDTH{w_sx & r_b[WIDTH-1]}}, r_b};
    assign w_prod  = w_a_ext * w_b_ext;
    assign w_hilo  = {r_hi, r_lo};

    always_comb begin
        w_mul_res = w_prod;
        if ((r_op == c_OP_MADD) || (r_op == c_OP_MADDU)) begin
            w_mul_res = w_hilo + w_prod;
        end else if ((r_op == c_OP_MSUB) || (r_op == c_OP_MSUBU)) begin
            w_mul_res = w_hilo - w_prod;
        end
    end

    mdu_div_core #(
        .WIDTH (WIDTH)
    ) u_div_core (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_signed (w_sx),
        .o_quo    (w_quo),
        .o_rem    (w_rem)
    );

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_op   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (start) begin
                    r_a  <= a;
                    r_b  <= b;
                    r_op <= op;
                    if (is_mul_op(op)) begin
                        r_cnt <= c_CNT_W'(MUL_LAT);
                    end else if (is_div_op(op)) begin
                        r_cnt <= c_CNT_W'(DIV_LAT);
                    end
                    if (op == c_OP_MTHI) begin
                        r_hi <= a;
                    end
                    if (op == c_OP_MTLO) begin
                        r_lo <= a;
                    end
                end
            end else begin
                r_cnt <= r_cnt - c_CNT_W'(1);
                if (w_last) begin
                    r_done <= 1'b1;
                    if (r_state == ST_MUL) begin
                        {r_hi, r_lo} <= w_mul_res;
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy = (r_state != ST_IDLE);
    assign done = r_done;

    always_comb begin
        result = '0;
        if (op == c_OP_MFHI) begin
            result = r_hi;
        end else if (op == c_OP_MFLO) begin
            result = r_lo;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Self-checking bench for muldiv_unit. Two instances: the
//                default 32-bit configuration and a 16-bit, single-cycle
//                multiply configuration. Expected HI/LO come from an
//                arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_muldiv_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        reset, start, busy, done;
    logic [3:0]  op;
    logic [31:0] a, b, result;

    // 16-bit instance
    logic        reset16, start16, busy16, done16;
    logic [3:0]  op16;
    logic [15:0] a16, b16, result16;

    muldiv_unit #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result)
    );

    muldiv_unit #(.WIDTH(16), .MUL_LAT(1), .DIV_LAT(10)) dut16 (
        .clk(clk), .reset(reset16), .start(start16), .op(op16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .result(result16)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] m_hi [2];
    logic [31:0] m_lo [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: the architectural effect of one op on HI/LO at width w.
    function automatic void ref_exec(input int w, input logic [3:0] o,
                                     input logic [31:0] x, input logic [31:0] y,
                                     inout logic [31:0] hi, inout logic [31:0] lo);
        logic [63:0] wm, dm, hilo, p;
        longint unsigned ux, uy;
        longint sx, sy;
        wm   = (64'd1 << w) - 64'd1;
        dm   = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2*w)) - 64'd1);
        ux   = longint'(64'(x) & wm);
        uy   = longint'(64'(y) & wm);
        sx   = x[w-1] ? longint'(ux) - (longint'(1) << w) : longint'(ux);
        sy   = y[w-1] ? longint'(uy) - (longint'(1) << w) : longint'(uy);
        hilo = ((64'(hi) & wm) << w) | (64'(lo) & wm);
        case (o)
            4'd2: hi = 32'(ux);
            4'd3: lo = 32'(ux);
            4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11: begin
                p = o[0] ? 64'(ux * uy) : 64'(sx * sy);
                if (o == 4'd8 || o == 4'd9)        hilo = hilo + p;
                else if (o == 4'd10 || o == 4'd11) hilo = hilo - p;
                else                               hilo = p;
                hilo = hilo & dm;
                hi   = 32'(hilo >> w);
                lo   = 32'(hilo & wm);
            end
            4'd6, 4'd7: begin
                if (uy == 0) begin
                    lo = 32'(wm);
                    hi = 32'(ux);
                end else if (o == 4'd6) begin
                    if (sx == -(longint'(1) << (w-1)) && sy == -1) begin
                        lo = 32'(ux);
                        hi = 32'd0;
                    end else begin
                        lo = 32'(64'(sx / sy) & wm);
                        hi = 32'(64'(sx % sy) & wm);
                    end
                end else begin
                    lo = 32'(ux / uy);
                    hi = 32'(ux % uy);
                end
            end
            default: ;
        endcase
    endfunction

    task automatic drive(input bit s, input logic st, input logic [3:0] o,
                         input logic [31:0] x, input logic [31:0] y);
        if (s) begin
            start16 = st; op16 = o; a16 = x[15:0]; b16 = y[15:0];
        end else begin
            start = st; op = o; a = x; b = y;
        end
    endtask

    function automatic logic [31:0] rd_result(input bit s);
        return s ? {16'd0, result16} : result;
    endfunction
    function automatic logic rd_busy(input bit s);
        return s ? busy16 : busy;
    endfunction
    function automatic logic rd_done(input bit s);
        return s ? done16 : done;
    endfunction

    task automatic read_reg(input bit s, input bit lo_sel, output logic [31:0] v);
        drive(s, 1'b0, lo_sel ? 4'd1 : 4'd0, $urandom, $urandom);
        #1;
        v = rd_result(s);
    endtask

    // Issue one op on instance s and check timing, busy-time reads and HI/LO.
    task automatic run_op(input bit s, input logic [3:0] o, input logic [31:0] x,
                          input logic [31:0] y, input bit inject, input string tag);
        int lat, n;
        logic [31:0] old_hi, e_hi, e_lo, v;
        if (o inside {4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11}) lat = s ? 1 : 5;
        else if (o inside {4'd6, 4'd7})                     lat = 10;
        else                                                 lat = 0;
        old_hi = m_hi[s];
        e_hi = m_hi[s];
        e_lo = m_lo[s];
        ref_exec(s ? 16 : 32, o, x, y, e_hi, e_lo);
        drive(s, 1'b1, o, x, y);
        @(posedge clk); #1;
        if (lat == 0) begin
            drive(s, 1'b0, 4'd0, $urandom, $urandom);
            #1;
            m_hi[s] = e_hi;
            m_lo[s] = e_lo;
            chk({tag, " busy(short)"}, 32'(rd_busy(s)), 32'd0);
            chk({tag, " done(short)"}, 32'(rd_done(s)), 32'd0);
        end else begin
            n = 0;
            while (rd_busy(s) === 1'b1 && n < 40) begin
                drive(s, 1'b0, 4'd0, $urandom, $urandom);
                #1;
                chk({tag, " HI during busy"}, rd_result(s), old_hi);
                chk({tag, " done during busy"}, 32'(rd_done(s)), 32'd0);
                if (inject && n == 1) drive(s, 1'b1, 4'd3, 32'd5, 32'd0);
                if (inject && n == 2) drive(s, 1'b1, 4'd6, $urandom, $urandom);
                n++;
                @(posedge clk); #1;
            end
            drive(s, 1'b0, 4'd0, $urandom, $urandom);
            chk({tag, " busy cycles"}, 32'(n), 32'(lat));
            chk({tag, " done pulse"}, 32'(rd_done(s)), 32'd1);
            m_hi[s] = e_hi;
            m_lo[s] = e_lo;
            @(posedge clk); #1;
            chk({tag, " done low"}, 32'(rd_done(s)), 32'd0);
        end
        read_reg(s, 1'b0, v);
        chk({tag, " HI"}, v, m_hi[s]);
        read_reg(s, 1'b1, v);
        chk({tag, " LO"}, v, m_lo[s]);
        drive(s, 1'b0, 4'($urandom_range(2, 15)), $urandom, $urandom);
        #1;
        chk({tag, " result other op"}, rd_result(s), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v, x, y;
        logic [3:0]  o;
        int          seen;

        reset = 1'b1;
        reset16 = 1'b1;
        drive(0, 1'b1, 4'd2, 32'hFFFF_FFFF, 32'd0);
        drive(1, 1'b0, 4'd0, 32'd0, 32'd0);
        m_hi[0] = '0; m_lo[0] = '0; m_hi[1] = '0; m_lo[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
        reset = 1'b0;
        reset16 = 1'b0;
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset HI", result, 32'd0);
        read_reg(0, 1'b1, v);
        chk("reset LO", v, 32'd0);

        // Directed cases
        run_op(0, 4'd4, 32'hFFFF_FFFE, 32'd3, 0, "MULT");
        read_reg(0, 1'b0, v); chk("MULT HI const", v, 32'hFFFF_FFFF);
        read_reg(0, 1'b1, v); chk("MULT LO const", v, 32'hFFFF_FFFA);
        run_op(0, 4'd6, -32'sd7, 32'd2, 0, "DIV -7/2");
        read_reg(0, 1'b1, v); chk("DIV LO const", v, 32'hFFFF_FFFD);
        read_reg(0, 1'b0, v); chk("DIV HI const", v, 32'hFFFF_FFFF);
        run_op(0, 4'd7, 32'd7, 32'd0, 0, "DIVU by 0");
        run_op(0, 4'd2, 32'h1234_5678, 32'd0, 0, "MTHI");
        run_op(0, 4'd3, 32'd1, 32'd0, 0, "MTLO");
        run_op(0, 4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "MADDU");
        read_reg(0, 1'b0, v); chk("MADDU HI const", v, 32'h1234_5676);
        read_reg(0, 1'b1, v); chk("MADDU LO const", v, 32'd2);
        run_op(0, 4'd5, $urandom, $urandom, 1, "MULTU ignore starts");
        run_op(0, 4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, "DIV overflow");
        run_op(0, 4'd6, 32'hFFFF_FF00, 32'd0, 0, "DIV by 0 neg");
        run_op(0, 4'd10, $urandom, $urandom, 0, "MSUB");
        run_op(0, 4'd11, $urandom, $urandom, 0, "MSUBU");
        run_op(0, 4'd8, 32'h8000_0000, 32'h8000_0000, 0, "MADD");
        run_op(0, 4'd6, 32'd7, -32'sd2, 0, "DIV 7/-2");
        run_op(0, 4'd13, $urandom, $urandom, 0, "NOP");

        // Randomized ops
        for (int i = 0; i < 30; i++) begin
            o = 4'($urandom_range(0, 15));
            x = $urandom;
            y = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (o == 4'd6 && $urandom_range(0, 5) == 0) begin
                x = 32'h8000_0000;
                y = 32'hFFFF_FFFF;
            end
            run_op(0, o, x, y, 0, "rand32");
        end

        // Reset during cycle 3 of a divide: abort without write or done
        drive(0, 1'b1, 4'd6, 32'd1000, 32'd7);
        @(posedge clk); #1;
        drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_hi[0] = '0;
        m_lo[0] = '0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0) seen = 1;
        end
        chk("abort no done", 32'(seen), 32'd0);
        read_reg(0, 1'b0, v); chk("abort HI", v, 32'd0);
        read_reg(0, 1'b1, v); chk("abort LO", v, 32'd0);

        // Reset wins over a simultaneous start
        reset = 1'b1;
        drive(0, 1'b1, 4'd2, 32'hDEAD_BEEF, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        drive(0, 1'b1, 4'd4, 32'd3, 32'd3);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
        #1;
        chk("reset vs start busy", 32'(busy), 32'd0);
        chk("reset vs start HI", result, 32'd0);
        run_op(0, 4'd7, 32'd100, 32'd9, 0, "DIVU after reset");

        // 16-bit instance, single-cycle multiply
        run_op(1, 4'd4, 32'h8000, 32'h8000, 0, "W16 MULT");
        read_reg(1, 1'b0, v); chk("W16 HI const", v, 32'h4000);
        read_reg(1, 1'b1, v); chk("W16 LO const", v, 32'h0000);
        run_op(1, 4'd6, 32'h8000, 32'hFFFF, 0, "W16 DIV overflow");
        run_op(1, 4'd7, 32'h1234, 32'd0, 0, "W16 DIVU by 0");
        for (int i = 0; i < 15; i++) begin
            o = 4'($urandom_range(2, 11));
            run_op(1, o, 32'($urandom_range(0, 65535)), 32'($urandom_range(0, 65535)), 0, "rand16");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
